// File: rtl/bin2bcd_converter.sv
// 32-bit binary to 10-digit BCD, shift-and-add-3, one bit per falling edge.
// Define BCD_BLANK_EN to add the per-digit leading-zero Blank output.
module bin2bcd_converter (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        start,
  input  logic [31:0] Bin,
  output logic [39:0] BCD,
  output logic        busy,
  output logic        done
`ifdef BCD_BLANK_EN
  ,
  output logic [9:0]  Blank
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] sh;
  logic [39:0] acc;
  logic [5:0]  cnt;

  logic [39:0] adj;
  logic [39:0] acc_nx;
  logic [31:0] sh_nx;

  function automatic logic [39:0] add3(input logic [39:0] a);
    logic [39:0] r;
    r = a;
    for (int i = 0; i < 10; i++) begin
      if (a[4*i +: 4] >= 4'd5)
        r[4*i +: 4] = a[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

`ifdef BCD_BLANK_EN
  // Blank[i] set when digit i and every digit above it are zero
  function automatic logic [9:0] blank_of(input logic [39:0] d);
    logic [9:0] b;
    logic       z;
    b = '0;
    z = 1'b1;
    for (int i = 9; i >= 1; i--) begin
      z    = z & (d[4*i +: 4] == 4'd0);
      b[i] = z;
    end
    return b;
  endfunction
`endif

  always_comb begin
    adj    = add3(acc);
    acc_nx = {adj[38:0], sh[31]};
    sh_nx  = {sh[30:0], 1'b0};
  end

  always_ff @(negedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= IDLE;
      sh    <= '0;
      acc   <= '0;
      cnt   <= '0;
      BCD   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef BCD_BLANK_EN
      Blank <= 10'b1111111110;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= SHIFT;
            sh    <= Bin;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
          end
        end
        SHIFT: begin
          acc <= acc_nx;
          sh  <= sh_nx;
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            BCD   <= acc_nx;
`ifdef BCD_BLANK_EN
            Blank <= blank_of(acc_nx);
`endif
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_converter.sv
// Bench for bin2bcd_converter: decimal-arithmetic model checked every
// cycle, plus directed conversions with literal expected digits.
module tb_bin2bcd_converter;

  logic        Clk;
  logic        Rst;
  logic        start;
  logic [31:0] Bin;
  logic [39:0] BCD;
  logic        busy;
  logic        done;
`ifdef BCD_BLANK_EN
  logic [9:0]  Blank;
`endif

  int checks = 0;
  int errors = 0;

  bin2bcd_converter dut (
    .Clk   (Clk),
    .Rst   (Rst),
    .start (start),
    .Bin   (Bin),
    .BCD   (BCD),
    .busy  (busy),
    .done  (done)
`ifdef BCD_BLANK_EN
    ,
    .Blank (Blank)
`endif
  );

  initial Clk = 1'b1;
  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [39:0] to_bcd(input logic [31:0] v);
    longint      x;
    logic [39:0] r;
    x = longint'(v);
    r = '0;
    for (int i = 0; i < 10; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [9:0] blank_model(input logic [39:0] d);
    logic [9:0] b;
    b = '0;
    for (int i = 1; i < 10; i++)
      b[i] = ((d >> (4*i)) == 40'd0);
    return b;
  endfunction

  // Model: a request is accepted when idle/done, result after 32 edges
  logic        m_busy;
  logic        m_done;
  logic [39:0] m_bcd;
  logic [31:0] m_val;
  int          m_left;

  always @(negedge Clk or posedge Rst) begin
    if (Rst) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_bcd  = '0;
      m_left = 0;
    end else if (m_busy) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_busy = 1'b0;
        m_done = 1'b1;
        m_bcd  = to_bcd(m_val);
      end
    end else if (start) begin
      m_val  = Bin;
      m_left = 32;
      m_busy = 1'b1;
      m_done = 1'b0;
    end
  end

  always @(posedge Clk) begin
    chk("busy", 64'(busy), 64'(m_busy));
    chk("done", 64'(done), 64'(m_done));
    chk("bcd", 64'(BCD), 64'(m_bcd));
`ifdef BCD_BLANK_EN
    chk("blank", 64'(Blank), 64'(blank_model(m_bcd)));
`endif
  end

  // Start a conversion at a posedge; optionally pulse start with Bin=99
  // at cycle inj of the shift phase. Returns edges until done seen.
  task automatic conv(input logic [31:0] v, input int inj, output int lat);
    int n;
    start = 1'b1;
    Bin   = v;
    @(posedge Clk);
    n = 1;
    while (!done && n < 40) begin
      start = (n == inj);
      Bin   = (n == inj) ? 32'd99 : $urandom;
      @(posedge Clk);
      n++;
    end
    start = 1'b0;
    lat   = n - 1;
  endtask

  int lat;

  initial begin
    Rst   = 1'b0;
    start = 1'b0;
    Bin   = '0;
    #1 Rst = 1'b1;
    @(posedge Clk);
    #1;
    chk("rst_bcd", 64'(BCD), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_done", 64'(done), 64'h0);
`ifdef BCD_BLANK_EN
    chk("rst_blank", 64'(Blank), 64'(10'b1111111110));
`endif
    start = 1'b1;
    Bin   = 32'd0;
    repeat (3) @(posedge Clk);
    chk("rst_ignores_start", 64'(busy), 64'h0);
    Rst = 1'b0;

    conv(32'd0, 0, lat);
    chk("lat_0", 64'(lat), 64'd32);
    chk("bcd_0", 64'(BCD), 64'h0);
`ifdef BCD_BLANK_EN
    chk("blank_0", 64'(Blank), 64'(10'b1111111110));
`endif

    conv(32'd1234, 0, lat);
    chk("lat_1234", 64'(lat), 64'd32);
    chk("bcd_1234", 64'(BCD), 64'h0000001234);
`ifdef BCD_BLANK_EN
    chk("blank_1234", 64'(Blank), 64'(10'b1111110000));
`endif

    conv(32'd4294967295, 0, lat);
    chk("bcd_max", 64'(BCD), 64'h4294967295);
`ifdef BCD_BLANK_EN
    chk("blank_max", 64'(Blank), 64'h0);
`endif

    repeat (3) @(posedge Clk);
    chk("done_hold", 64'(done), 64'h1);
    conv(32'd1000000005, 0, lat);
    chk("bcd_1e9", 64'(BCD), 64'h1000000005);

    conv(32'd1234, 5, lat);
    chk("lat_ignore", 64'(lat), 64'd32);
    chk("bcd_ignore", 64'(BCD), 64'h0000001234);
    conv(32'd99, 0, lat);
    chk("bcd_99", 64'(BCD), 64'h0000000099);
`ifdef BCD_BLANK_EN
    chk("blank_99", 64'(Blank), 64'(10'b1111111100));
`endif

    start = 1'b1;
    Bin   = 32'd5000;
    @(posedge Clk);
    start = 1'b0;
    repeat (10) @(posedge Clk);
    #2 Rst = 1'b1;
    #1;
    chk("abort_busy", 64'(busy), 64'h0);
    chk("abort_done", 64'(done), 64'h0);
    chk("abort_bcd", 64'(BCD), 64'h0);
    @(posedge Clk);
    Rst = 1'b0;
    repeat (40) @(posedge Clk);
    chk("abort_no_done", 64'(done), 64'h0);
    chk("abort_no_bcd", 64'(BCD), 64'h0);

    conv(32'd59, 0, lat);
    chk("bcd_59", 64'(BCD), 64'h0000000059);
    chk("lat_59", 64'(lat), 64'd32);

    repeat (2) @(posedge Clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
